// File: rtl/jaxa_spw_pkg.sv
// -----------------------------------------------------------------------------
// jaxa_spw_pkg
// Shared types for the SpaceWire time-code path of the JAXA codec.
//   TIME_W / FLAG_W : time-code value width (bits 5:0) and control-flag width
//                     (bits 7:6)
//   ctrl_flags_t    : control-flag field
//   time_val_t      : time-code value field
//   cf_state_t      : tick sequence-tracking state
// -----------------------------------------------------------------------------
package jaxa_spw_pkg;

    localparam int TIME_W = 6;
    localparam int FLAG_W = 2;

    typedef logic [FLAG_W-1:0] ctrl_flags_t;
    typedef logic [TIME_W-1:0] time_val_t;

    typedef enum logic [1:0] {
        CF_IDLE,
        CF_SYNC,
        CF_TRACK
    } cf_state_t;

endpackage

// File: rtl/jaxa_ctrl_flags_capture_if.sv
// -----------------------------------------------------------------------------
// jaxa_ctrl_flags_capture_if
// Tick bus from the codec time-code receiver.
//   tick_in : 1-cycle pulse, a time-code has been received
//   ctrl_in : control flags, valid while tick_in = 1
//   time_in : time value, valid while tick_in = 1
// Modports: master = codec side (drives), slave = capture side (samples).
// -----------------------------------------------------------------------------
interface jaxa_ctrl_flags_capture_if #(
    parameter int FLAG_W = jaxa_spw_pkg::FLAG_W,
    parameter int TIME_W = jaxa_spw_pkg::TIME_W
);

    logic              tick_in;
    logic [FLAG_W-1:0] ctrl_in;
    logic [TIME_W-1:0] time_in;

    modport master (output tick_in, output ctrl_in, output time_in);
    modport slave  (input  tick_in, input  ctrl_in, input  time_in);

endinterface

// File: rtl/jaxa_tick_seq_checker.sv
// -----------------------------------------------------------------------------
// jaxa_tick_seq_checker
// Tracks accepted ticks and flags a time value that did not advance by one
// (mod 2^TIME_W). The first accepted tick only seeds the reference and the
// second moves into tracking; comparisons start from the third tick.
// Only built when JAXA_CTRL_FLAGS_SEQCHK_EN is defined.
//   clk, reset_n : clock, asynchronous active-low reset
//   accept       : tick accepted this cycle
//   clr          : clear seq_err and restart tracking (wins over an error)
//   time_in      : time value of the current tick
//   time_last    : last accepted time value
//   seq_err      : sticky sequence error
// -----------------------------------------------------------------------------
`ifdef JAXA_CTRL_FLAGS_SEQCHK_EN
module jaxa_tick_seq_checker #(
    parameter int TIME_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              accept,
    input  logic              clr,
    input  logic [TIME_W-1:0] time_in,
    input  logic [TIME_W-1:0] time_last,
    output logic              seq_err
);
    import jaxa_spw_pkg::*;

    cf_state_t         state_q;
    cf_state_t         state_d;
    logic              err_d;
    logic [TIME_W-1:0] time_exp;

    // Natural wrap of the TIME_W-bit add makes 63 -> 0 a valid step.
    assign time_exp = time_last + TIME_W'(1);

    always_comb begin
        state_d = state_q;
        err_d   = seq_err;
        if (clr) begin
            err_d   = 1'b0;
            state_d = accept ? CF_SYNC : CF_IDLE;
        end else if (accept) begin
            case (state_q)
                CF_IDLE: state_d = CF_SYNC;
                CF_SYNC: state_d = CF_TRACK;
                default: begin
                    state_d = CF_TRACK;
                    if (time_in != time_exp)
                        err_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CF_IDLE;
            seq_err <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_err <= err_d;
        end
    end

endmodule
`endif

// File: rtl/jaxa_ctrl_flags_capture.sv
// -----------------------------------------------------------------------------
// jaxa_ctrl_flags_capture
// Captures time-code control flags from the codec tick bus and holds them for
// the 2-bit control-flags PIO port; adds a tick counter, a stretched tick
// indication and (optionally) time-value sequence checking.
// Build option: JAXA_CTRL_FLAGS_SEQCHK_EN adds the sequence checker; without
// it seq_err is tied low and tracking is reduced to IDLE/TRACK.
//   clk, reset_n : clock, asynchronous active-low reset
//   tick_bus     : slave side of the codec tick bus (tick_in/ctrl_in/time_in)
//   freeze       : hold all captured outputs and ignore ticks
//   clr_status   : 1-cycle pulse, clear seq_err and tick_count
//   flags_out    : last accepted control flags
//   time_out     : last accepted time value
//   tick_count   : accepted ticks, wraps modulo 2^CNT_W
//   tick_stretch : high STRETCH cycles after each accepted tick
//   seq_err      : sticky time-sequence error
// -----------------------------------------------------------------------------
module jaxa_ctrl_flags_capture #(
    parameter int FLAG_W  = 2,
    parameter int TIME_W  = 6,
    parameter int CNT_W   = 16,
    parameter int STRETCH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    jaxa_ctrl_flags_capture_if.slave    tick_bus,
    input  logic                        freeze,
    input  logic                        clr_status,
    output logic [FLAG_W-1:0]           flags_out,
    output logic [TIME_W-1:0]           time_out,
    output logic [CNT_W-1:0]            tick_count,
    output logic                        tick_stretch,
    output logic                        seq_err
);
    import jaxa_spw_pkg::*;

    logic       accept;
    logic [3:0] stretch_cnt;

    assign accept = tick_bus.tick_in & ~freeze;

    // Captured flags/time and the accepted-tick counter. A clear coinciding
    // with an accept counts that tick, so the counter restarts at 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_out  <= '0;
            time_out   <= '0;
            tick_count <= '0;
        end else begin
            if (accept) begin
                flags_out <= tick_bus.ctrl_in;
                time_out  <= tick_bus.time_in;
            end
            if (clr_status)
                tick_count <= accept ? CNT_W'(1) : '0;
            else if (accept)
                tick_count <= tick_count + CNT_W'(1);
        end
    end

    // Retriggerable stretch: reload on every accept, otherwise count down.
    // Keeps running while frozen so an indication in flight still expires.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stretch_cnt <= '0;
        else if (accept)
            stretch_cnt <= 4'(STRETCH);
        else if (stretch_cnt != 4'd0)
            stretch_cnt <= stretch_cnt - 4'd1;
    end

    assign tick_stretch = (stretch_cnt != 4'd0);

`ifdef JAXA_CTRL_FLAGS_SEQCHK_EN
    jaxa_tick_seq_checker #(
        .TIME_W (TIME_W)
    ) u_seq_checker (
        .clk       (clk),
        .reset_n   (reset_n),
        .accept    (accept),
        .clr       (clr_status),
        .time_in   (tick_bus.time_in),
        .time_last (time_out),
        .seq_err   (seq_err)
    );
`else
    // Reduced tracking: only "seen a tick since reset/clear" is kept.
    cf_state_t state_q;
    cf_state_t state_d;

    always_comb begin
        state_d = state_q;
        if (clr_status)
            state_d = accept ? CF_TRACK : CF_IDLE;
        else if (accept)
            state_d = CF_TRACK;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= CF_IDLE;
        else
            state_q <= state_d;
    end

    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_jaxa_ctrl_flags_capture.sv
// -----------------------------------------------------------------------------
// tb_jaxa_ctrl_flags_capture
// Scoreboard bench: each driven cycle pushes the expected post-edge outputs
// from a behavioural model; the entry is popped and compared after the edge.
// -----------------------------------------------------------------------------
module tb_jaxa_ctrl_flags_capture;

    localparam int STRETCH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        freeze = 1'b0;
    logic        clr_status = 1'b0;
    logic [1:0]  flags_out;
    logic [5:0]  time_out;
    logic [15:0] tick_count;
    logic        tick_stretch;
    logic        seq_err;

    jaxa_ctrl_flags_capture_if tb_if ();

    jaxa_ctrl_flags_capture #(
        .FLAG_W  (2),
        .TIME_W  (6),
        .CNT_W   (16),
        .STRETCH (STRETCH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick_bus     (tb_if),
        .freeze       (freeze),
        .clr_status   (clr_status),
        .flags_out    (flags_out),
        .time_out     (time_out),
        .tick_count   (tick_count),
        .tick_stretch (tick_stretch),
        .seq_err      (seq_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  flags;
        logic [5:0]  tm;
        logic [15:0] cnt;
        logic        str;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    // Behavioural model state
    logic [1:0]  m_flags;
    logic [5:0]  m_time;
    logic [15:0] m_cnt;
    int          m_str;
    logic        m_err;
    int          m_st;   // 0 = idle, 1 = sync, 2 = track

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_flags = '0;
        m_time  = '0;
        m_cnt   = '0;
        m_str   = 0;
        m_err   = 1'b0;
        m_st    = 0;
    endtask

    task automatic step(input logic tick, input logic [1:0] ctrl, input logic [5:0] tm,
                        input logic frz, input logic clr);
        logic acc;
        logic n_err;
        int   n_st;
        exp_t e;
        exp_t got_e;
        tb_if.tick_in = tick;
        tb_if.ctrl_in = ctrl;
        tb_if.time_in = tm;
        freeze        = frz;
        clr_status    = clr;

        acc   = tick && !frz;
        n_err = m_err;
        n_st  = m_st;
`ifdef JAXA_CTRL_FLAGS_SEQCHK_EN
        if (clr) begin
            n_err = 1'b0;
            n_st  = acc ? 1 : 0;
        end else if (acc) begin
            if (m_st == 0)      n_st = 1;
            else if (m_st == 1) n_st = 2;
            else begin
                n_st = 2;
                if (int'(tm) != ((int'(m_time) + 1) % 64)) n_err = 1'b1;
            end
        end
`else
        if (clr)      n_st = acc ? 2 : 0;
        else if (acc) n_st = 2;
        n_err = 1'b0;
`endif
        if (clr)      m_cnt = acc ? 16'd1 : 16'd0;
        else if (acc) m_cnt = m_cnt + 16'd1;
        if (acc) begin
            m_flags = ctrl;
            m_time  = tm;
            m_str   = STRETCH;
        end else if (m_str > 0) begin
            m_str = m_str - 1;
        end
        m_err = n_err;
        m_st  = n_st;

        e.flags = m_flags;
        e.tm    = m_time;
        e.cnt   = m_cnt;
        e.str   = (m_str != 0);
        e.err   = m_err;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        got_e = sb_q.pop_front();
        chk("flags_out",    32'(flags_out),    32'(got_e.flags));
        chk("time_out",     32'(time_out),     32'(got_e.tm));
        chk("tick_count",   32'(tick_count),   32'(got_e.cnt));
        chk("tick_stretch", 32'(tick_stretch), 32'(got_e.str));
        chk("seq_err",      32'(seq_err),      32'(got_e.err));
        tb_if.tick_in = 1'b0;
        clr_status    = 1'b0;
    endtask

    // Idle cycles drive random ctrl/time to show they are ignored without tick.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 2'($urandom), 6'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tb_if.tick_in = 1'b0;
        tb_if.ctrl_in = '0;
        tb_if.time_in = '0;
        model_reset();

        // Reset state while reset_n is held low
        #1;
        chk("rst_flags",   32'(flags_out),    32'd0);
        chk("rst_time",    32'(time_out),     32'd0);
        chk("rst_count",   32'(tick_count),   32'd0);
        chk("rst_stretch", 32'(tick_stretch), 32'd0);
        chk("rst_seq_err", 32'(seq_err),      32'd0);
        #21;
        reset_n = 1'b1;

        // 1: no ticks for 100 cycles
        idle(100);

        // 2: single tick, stretch for 4 cycles
        step(1'b1, 2'b10, 6'd5, 1'b0, 1'b0);
        idle(5);

        // 3: wrap 63 -> 0 is a valid step, skip to 3 is an error
        step(1'b1, 2'b00, 6'd62, 1'b0, 1'b0);
        step(1'b1, 2'b01, 6'd63, 1'b0, 1'b0);
        step(1'b1, 2'b10, 6'd0,  1'b0, 1'b0);
        step(1'b1, 2'b11, 6'd1,  1'b0, 1'b0);
        step(1'b1, 2'b00, 6'd3,  1'b0, 1'b0);
`ifdef JAXA_CTRL_FLAGS_SEQCHK_EN
        chk("seq_err_set", 32'(seq_err), 32'd1);
`else
        chk("seq_err_tied", 32'(seq_err), 32'd0);
`endif
        idle(3);

        // 4: frozen tick is ignored, next unfrozen tick is captured
        step(1'b1, 2'b01, 6'd7, 1'b1, 1'b0);
        chk("frz_flags", 32'(flags_out), 32'(2'b00));
        step(1'b0, 2'b00, 6'd0, 1'b1, 1'b0);
        step(1'b1, 2'b11, 6'd4, 1'b0, 1'b0);
        chk("unfrz_flags", 32'(flags_out), 32'(2'b11));
        idle(2);

        // 5: clear together with a tick, then the next tick is not checked
        step(1'b1, 2'b00, 6'd9,  1'b0, 1'b1);
        chk("clr_count", 32'(tick_count), 32'd1);
        step(1'b1, 2'b01, 6'd20, 1'b0, 1'b0);
        step(1'b1, 2'b10, 6'd21, 1'b0, 1'b0);
        step(1'b1, 2'b10, 6'd30, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 2'b00, 6'd0,  1'b0, 1'b1);
        idle(2);

        // 6: ticks two cycles apart keep stretch high; async reset mid-stretch
        step(1'b1, 2'b11, 6'd31, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 2'b01, 6'd32, 1'b0, 1'b0);
        idle(1);
        step(1'b1, 2'b10, 6'd33, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_flags",   32'(flags_out),    32'd0);
        chk("arst_time",    32'(time_out),     32'd0);
        chk("arst_count",   32'(tick_count),   32'd0);
        chk("arst_stretch", 32'(tick_stretch), 32'd0);
        chk("arst_seq_err", 32'(seq_err),      32'd0);
        model_reset();
        #3;
        reset_n = 1'b1;
        idle(3);
        step(1'b1, 2'b01, 6'd40, 1'b0, 1'b0);
        idle(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
